// File: rtl/uart_reg_pkg.sv
// ============================================================================
// Module      : uart_reg_pkg
// Description : Shared constants, burst state type and bus-slicing helper
//               for the multi-channel UART register bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_reg_pkg;

    localparam int C_CTRL_SEND  = 0;
    localparam int C_CTRL_READ  = 1;
    localparam int C_CTRL_FTXF  = 2;
    localparam int C_CTRL_RXAV  = 3;
    localparam int C_CTRL_WERR  = 4;
    localparam int C_CTRL_RXIE  = 5;
    localparam int C_CTRL_PACK  = 6;
    localparam int C_CTRL_TXCNT = 8;
    localparam int C_CTRL_TXIE  = 30;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PUSH = 1'b1
    } burst_state_t;

    // Low bit index of channel ch in a flattened bus of w-bit fields.
    function automatic int ch_slice(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_packer.sv
// ============================================================================
// Module      : uart_tx_packer
// Description : Burst engine that unpacks 1-4 bytes from a latched data word
//               into one channel's TX FIFO, LSB first, stalling on full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_packer
    import uart_reg_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [CH_W-1:0]       i_ch,
    input  logic [WIDTH-1:0]      i_word,
    input  logic [1:0]            i_len_m1,
    input  logic [NUM_CH-1:0]     i_tx_full,
    output logic                  o_busy,
    output logic [NUM_CH-1:0]     o_busy_ch,
    output logic [NUM_CH-1:0]     o_push_en,
    output logic [8*NUM_CH-1:0]   o_push_data
);

    // Word is widened so byte 3 is always addressable even on narrow buses.
    localparam int WW = (WIDTH > 32) ? WIDTH : 32;

    burst_state_t    r_state_q, w_state_d;
    logic [1:0]      r_idx_q, w_idx_d;
    logic [1:0]      r_len_q, w_len_d;
    logic [WW-1:0]   r_word_q, w_word_d;
    logic [CH_W-1:0] r_ch_q, w_ch_d;
    logic            w_full;
    logic            w_push;
    logic [7:0]      w_byte;

    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_len_d   = r_len_q;
        w_word_d  = r_word_q;
        w_ch_d    = r_ch_q;
        w_full    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(r_ch_q) == c) w_full = i_tx_full[c];
        end
        w_byte = r_word_q[8*r_idx_q +: 8];
        w_push = (r_state_q == ST_PUSH) && !w_full;

        case (r_state_q)
            ST_IDLE: begin
                if (i_start) begin
                    w_word_d  = WW'(i_word);
                    w_ch_d    = i_ch;
                    w_len_d   = i_len_m1;
                    w_idx_d   = 2'd0;
                    w_state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (w_push) begin
                    if (r_idx_q == r_len_q) w_state_d = ST_IDLE;
                    else                    w_idx_d   = r_idx_q + 2'd1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        o_busy      = (r_state_q == ST_PUSH);
        o_busy_ch   = '0;
        o_push_en   = '0;
        o_push_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            o_busy_ch[c] = o_busy && (int'(r_ch_q) == c);
            o_push_en[c] = w_push && (int'(r_ch_q) == c);
            if (o_push_en[c]) o_push_data[ch_slice(c, 8) +: 8] = w_byte;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state_q <= ST_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_word_q  <= '0;
            r_ch_q    <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_len_q   <= w_len_d;
            r_word_q  <= w_word_d;
            r_ch_q    <= w_ch_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_reg_bank.sv
// ============================================================================
// Module      : uart_reg_bank
// Description : NUM_CH-channel UART control/data register bank on one agent
//               bus. Optional interrupt output enabled by UART_REG_BANK_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_reg_bank
    import uart_reg_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int CNT_WIDTH = 9,
    parameter  int NUM_CH    = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [CH_W-1:0]               i_ch_sel,
    input  logic                          i_reg_sel,
    input  logic                          i_wr,
    input  logic                          i_rd,
    input  logic [WIDTH-1:0]              i_reg_wr_data,
    output logic [WIDTH-1:0]              o_reg_rd_data,
    output logic                          o_busy,
    output logic [NUM_CH-1:0]             o_fifo_tx_push_en,
    output logic [8*NUM_CH-1:0]           o_fifo_tx_push_data,
    input  logic [CNT_WIDTH*NUM_CH-1:0]   i_fifo_tx_count,
    input  logic [NUM_CH-1:0]             i_fifo_tx_full,
    input  logic [8*NUM_CH-1:0]           i_fifo_rx_data,
    input  logic [NUM_CH-1:0]             i_fifo_rx_valid,
    input  logic [CNT_WIDTH*NUM_CH-1:0]   i_fifo_rx_count,
    output logic [NUM_CH-1:0]             o_fifo_rx_pop_en,
    input  logic [NUM_CH-1:0]             i_scdc_set_send,
    input  logic [NUM_CH-1:0]             i_scdc_clear_send,
    input  logic [NUM_CH-1:0]             i_scdc_set_read,
    input  logic [NUM_CH-1:0]             i_scdc_clear_read,
    output logic [NUM_CH-1:0]             o_send_req,
    output logic [NUM_CH-1:0]             o_read_req,
    output logic [NUM_CH-1:0]             o_ftxf,
`ifdef UART_REG_BANK_IRQ_EN
    output logic [NUM_CH-1:0]             o_irq,
`endif
    output logic [NUM_CH-1:0]             o_rxav
);

    localparam int NUM_SLOTS = 2**CH_W;

    logic [NUM_CH-1:0]   r_send_q, w_send_d;
    logic [NUM_CH-1:0]   r_read_q, w_read_d;
    logic [NUM_CH-1:0]   r_werr_q, w_werr_d;
    logic [2*NUM_CH-1:0] r_pack_q, w_pack_d;
`ifdef UART_REG_BANK_IRQ_EN
    logic [NUM_CH-1:0]   r_rxie_q, w_rxie_d;
    logic [NUM_CH-1:0]   r_txie_q, w_txie_d;
    logic [NUM_CH-1:0]   r_irq_q,  w_irq_d;
`endif

    logic [NUM_CH-1:0]   w_ch_hit;
    logic                w_ch_ok;
    logic                w_ctrl_wr;
    logic                w_data_wr;
    logic                w_start;
    logic                w_busy;
    logic [NUM_CH-1:0]   w_busy_ch;
    logic [1:0]          w_len_m1;
    logic [WIDTH-1:0]    w_ctrl_word [NUM_SLOTS];

    always_comb begin
        w_len_m1 = 2'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_ch_hit[c] = (int'(i_ch_sel) == c);
            if (w_ch_hit[c]) w_len_m1 = r_pack_q[ch_slice(c, 2) +: 2];
        end
        w_ch_ok   = |w_ch_hit;
        w_ctrl_wr = i_wr && !i_reg_sel && w_ch_ok;
        w_data_wr = i_wr &&  i_reg_sel && w_ch_ok;
        w_start   = w_data_wr && !w_busy;
    end

    uart_tx_packer #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_packer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (w_start),
        .i_ch        (i_ch_sel),
        .i_word      (i_reg_wr_data),
        .i_len_m1    (w_len_m1),
        .i_tx_full   (i_fifo_tx_full),
        .o_busy      (w_busy),
        .o_busy_ch   (w_busy_ch),
        .o_push_en   (o_fifo_tx_push_en),
        .o_push_data (o_fifo_tx_push_data)
    );

    // scdc clear beats scdc set, and both beat an agent write.
    always_comb begin
        w_send_d = r_send_q;
        w_read_d = r_read_q;
        w_werr_d = r_werr_q;
        w_pack_d = r_pack_q;
`ifdef UART_REG_BANK_IRQ_EN
        w_rxie_d = r_rxie_q;
        w_txie_d = r_txie_q;
        w_irq_d  = '0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_scdc_clear_send[c])              w_send_d[c] = 1'b0;
            else if (i_scdc_set_send[c])           w_send_d[c] = 1'b1;
            else if (w_ctrl_wr && w_ch_hit[c])     w_send_d[c] = i_reg_wr_data[C_CTRL_SEND];

            if (i_scdc_clear_read[c])              w_read_d[c] = 1'b0;
            else if (i_scdc_set_read[c])           w_read_d[c] = 1'b1;
            else if (w_ctrl_wr && w_ch_hit[c])     w_read_d[c] = i_reg_wr_data[C_CTRL_READ];

            if (w_data_wr && w_busy && w_ch_hit[c])
                w_werr_d[c] = 1'b1;
            else if (w_ctrl_wr && w_ch_hit[c] && i_reg_wr_data[C_CTRL_WERR])
                w_werr_d[c] = 1'b0;

            if (w_ctrl_wr && w_ch_hit[c])
                w_pack_d[ch_slice(c, 2) +: 2] = i_reg_wr_data[C_CTRL_PACK +: 2];
`ifdef UART_REG_BANK_IRQ_EN
            if (w_ctrl_wr && w_ch_hit[c]) begin
                w_rxie_d[c] = i_reg_wr_data[C_CTRL_RXIE];
                w_txie_d[c] = i_reg_wr_data[C_CTRL_TXIE];
            end
            w_irq_d[c] = (r_rxie_q[c] && i_fifo_rx_valid[c]) ||
                         (r_txie_q[c] && (i_fifo_tx_count[ch_slice(c, CNT_WIDTH) +: CNT_WIDTH] == '0)
                                      && !w_busy_ch[c]);
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_send_q <= '0;
            r_read_q <= '0;
            r_werr_q <= '0;
            r_pack_q <= '0;
`ifdef UART_REG_BANK_IRQ_EN
            r_rxie_q <= '0;
            r_txie_q <= '0;
            r_irq_q  <= '0;
`endif
        end else begin
            r_send_q <= w_send_d;
            r_read_q <= w_read_d;
            r_werr_q <= w_werr_d;
            r_pack_q <= w_pack_d;
`ifdef UART_REG_BANK_IRQ_EN
            r_rxie_q <= w_rxie_d;
            r_txie_q <= w_txie_d;
            r_irq_q  <= w_irq_d;
`endif
        end
    end

    // Unused selector slots stay zero so out-of-range channels read 0.
    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) w_ctrl_word[s] = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_ctrl_word[c][C_CTRL_SEND]     = r_send_q[c];
            w_ctrl_word[c][C_CTRL_READ]     = r_read_q[c];
            w_ctrl_word[c][C_CTRL_FTXF]     = i_fifo_tx_full[c];
            w_ctrl_word[c][C_CTRL_RXAV]     = i_fifo_rx_valid[c];
            w_ctrl_word[c][C_CTRL_WERR]     = r_werr_q[c];
            w_ctrl_word[c][C_CTRL_PACK +: 2] = r_pack_q[ch_slice(c, 2) +: 2];
            w_ctrl_word[c][C_CTRL_TXCNT +: CNT_WIDTH] =
                i_fifo_tx_count[ch_slice(c, CNT_WIDTH) +: CNT_WIDTH];
            w_ctrl_word[c][C_CTRL_TXCNT + CNT_WIDTH +: CNT_WIDTH] =
                i_fifo_rx_count[ch_slice(c, CNT_WIDTH) +: CNT_WIDTH];
`ifdef UART_REG_BANK_IRQ_EN
            w_ctrl_word[c][C_CTRL_RXIE] = r_rxie_q[c];
            w_ctrl_word[c][C_CTRL_TXIE] = r_txie_q[c];
`endif
        end
    end

    always_comb begin
        o_reg_rd_data    = '0;
        o_fifo_rx_pop_en = '0;
        if (i_rd && w_ch_ok) begin
            if (!i_reg_sel) begin
                o_reg_rd_data = w_ctrl_word[i_ch_sel];
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_ch_hit[c] && i_fifo_rx_valid[c]) begin
                        o_reg_rd_data       = WIDTH'({1'b1, i_fifo_rx_data[ch_slice(c, 8) +: 8]});
                        o_fifo_rx_pop_en[c] = 1'b1;
                    end
                end
            end
        end
    end

    assign o_busy     = w_busy;
    assign o_send_req = r_send_q;
    assign o_read_req = r_read_q;
    assign o_ftxf     = i_fifo_tx_full;
    assign o_rxav     = i_fifo_rx_valid;
`ifdef UART_REG_BANK_IRQ_EN
    assign o_irq      = r_irq_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_reg_bank.sv
// ============================================================================
// Module      : tb_uart_reg_bank
// Description : Directed self-checking bench for uart_reg_bank (2 channels).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_reg_bank;

    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 9;
    localparam int NUM_CH    = 2;
    localparam int CH_W      = 1;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [CH_W-1:0]             i_ch_sel;
    logic                        i_reg_sel, i_wr, i_rd;
    logic [WIDTH-1:0]            i_reg_wr_data;
    logic [WIDTH-1:0]            o_reg_rd_data;
    logic                        o_busy;
    logic [NUM_CH-1:0]           o_fifo_tx_push_en;
    logic [8*NUM_CH-1:0]         o_fifo_tx_push_data;
    logic [CNT_WIDTH*NUM_CH-1:0] i_fifo_tx_count, i_fifo_rx_count;
    logic [NUM_CH-1:0]           i_fifo_tx_full, i_fifo_rx_valid;
    logic [8*NUM_CH-1:0]         i_fifo_rx_data;
    logic [NUM_CH-1:0]           o_fifo_rx_pop_en;
    logic [NUM_CH-1:0]           i_scdc_set_send, i_scdc_clear_send;
    logic [NUM_CH-1:0]           i_scdc_set_read, i_scdc_clear_read;
    logic [NUM_CH-1:0]           o_send_req, o_read_req, o_ftxf, o_rxav;
`ifdef UART_REG_BANK_IRQ_EN
    logic [NUM_CH-1:0]           o_irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_reg_bank #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .NUM_CH    (NUM_CH)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_ch_sel            (i_ch_sel),
        .i_reg_sel           (i_reg_sel),
        .i_wr                (i_wr),
        .i_rd                (i_rd),
        .i_reg_wr_data       (i_reg_wr_data),
        .o_reg_rd_data       (o_reg_rd_data),
        .o_busy              (o_busy),
        .o_fifo_tx_push_en   (o_fifo_tx_push_en),
        .o_fifo_tx_push_data (o_fifo_tx_push_data),
        .i_fifo_tx_count     (i_fifo_tx_count),
        .i_fifo_tx_full      (i_fifo_tx_full),
        .i_fifo_rx_data      (i_fifo_rx_data),
        .i_fifo_rx_valid     (i_fifo_rx_valid),
        .i_fifo_rx_count     (i_fifo_rx_count),
        .o_fifo_rx_pop_en    (o_fifo_rx_pop_en),
        .i_scdc_set_send     (i_scdc_set_send),
        .i_scdc_clear_send   (i_scdc_clear_send),
        .i_scdc_set_read     (i_scdc_set_read),
        .i_scdc_clear_read   (i_scdc_clear_read),
        .o_send_req          (o_send_req),
        .o_read_req          (o_read_req),
        .o_ftxf              (o_ftxf),
`ifdef UART_REG_BANK_IRQ_EN
        .o_irq               (o_irq),
`endif
        .o_rxav              (o_rxav)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic ctrl_wr(input logic [CH_W-1:0] ch, input logic [31:0] data);
        i_ch_sel = ch; i_reg_sel = 1'b0; i_wr = 1'b1; i_reg_wr_data = data;
        tick();
        i_wr = 1'b0;
    endtask

    task automatic ctrl_rd_chk(input string tag, input logic [CH_W-1:0] ch, input logic [31:0] exp);
        i_ch_sel = ch; i_reg_sel = 1'b0; i_rd = 1'b1;
        #1;
        chk(tag, o_reg_rd_data, exp);
        i_rd = 1'b0;
    endtask

    logic [7:0] exp_b [4];

    initial begin
        rst = 1'b1;
        i_ch_sel = '0; i_reg_sel = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_reg_wr_data = '0;
        i_fifo_tx_count = '0; i_fifo_rx_count = '0; i_fifo_tx_full = '0;
        i_fifo_rx_valid = '0; i_fifo_rx_data = '0;
        i_scdc_set_send = '0; i_scdc_clear_send = '0;
        i_scdc_set_read = '0; i_scdc_clear_read = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // 1: reset state
        ctrl_rd_chk("rst_ctrl0", 1'b0, 32'h0);
        ctrl_rd_chk("rst_ctrl1", 1'b1, 32'h0);
        chk("rst_busy",   32'(o_busy), 32'h0);
        chk("rst_push",   32'(o_fifo_tx_push_en), 32'h0);
        chk("rst_send",   32'(o_send_req), 32'h0);
        chk("rst_read",   32'(o_read_req), 32'h0);
        chk("rst_pop",    32'(o_fifo_rx_pop_en), 32'h0);

        // 2: ch1 4-byte burst
        ctrl_wr(1'b1, 32'h0000_00C0);
        ctrl_rd_chk("t2_pack", 1'b1, 32'h0000_00C0);
        i_ch_sel = 1'b1; i_reg_sel = 1'b1; i_wr = 1'b1; i_reg_wr_data = 32'hDDCC_BBAA;
        tick();
        i_wr = 1'b0;
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_busy", 32'(o_busy), 32'h1);
            chk("t2_pushen", 32'(o_fifo_tx_push_en), 32'h2);
            chk("t2_byte", 32'(o_fifo_tx_push_data), {16'h0, exp_b[k], 8'h00});
            tick();
        end
        #1;
        chk("t2_idle_busy", 32'(o_busy), 32'h0);
        chk("t2_idle_push", 32'(o_fifo_tx_push_en), 32'h0);

        // 3: ch0 2-byte burst with a 3-cycle full stall
        ctrl_wr(1'b0, 32'h0000_0040);
        i_ch_sel = 1'b0; i_reg_sel = 1'b1; i_wr = 1'b1; i_reg_wr_data = 32'h0000_2211;
        tick();
        i_wr = 1'b0;
        #1;
        chk("t3_push0", 32'(o_fifo_tx_push_en), 32'h1);
        chk("t3_byte0", 32'(o_fifo_tx_push_data), 32'h0000_0011);
        tick();
        i_fifo_tx_full = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_stall_push", 32'(o_fifo_tx_push_en), 32'h0);
            chk("t3_stall_busy", 32'(o_busy), 32'h1);
            chk("t3_ftxf", 32'(o_ftxf), 32'h1);
            tick();
        end
        i_fifo_tx_full = 2'b00;
        #1;
        chk("t3_push1", 32'(o_fifo_tx_push_en), 32'h1);
        chk("t3_byte1", 32'(o_fifo_tx_push_data), 32'h0000_0022);
        tick();
        #1;
        chk("t3_done_busy", 32'(o_busy), 32'h0);
        chk("t3_done_push", 32'(o_fifo_tx_push_en), 32'h0);

        // 4: data write while busy is dropped and flags werr
        i_ch_sel = 1'b1; i_reg_sel = 1'b1; i_wr = 1'b1; i_reg_wr_data = 32'h4433_2211;
        tick();
        i_ch_sel = 1'b0; i_reg_wr_data = 32'h0000_0099;
        #1;
        chk("t4_b0", 32'(o_fifo_tx_push_data), 32'h0000_1100);
        tick();
        i_wr = 1'b0;
        #1;
        chk("t4_b1", 32'(o_fifo_tx_push_data), 32'h0000_2200);
        chk("t4_b1_en", 32'(o_fifo_tx_push_en), 32'h2);
        ctrl_rd_chk("t4_werr_set", 1'b0, 32'h0000_0050);
        ctrl_rd_chk("t4_werr_ch1", 1'b1, 32'h0000_00C0);
        tick(); tick(); tick();
        #1;
        chk("t4_end_busy", 32'(o_busy), 32'h0);
        chk("t4_end_push", 32'(o_fifo_tx_push_en), 32'h0);
        ctrl_wr(1'b0, 32'h0000_0050);
        ctrl_rd_chk("t4_werr_clr", 1'b0, 32'h0000_0040);

        // 5: RX data read with and without valid
        i_fifo_rx_valid = 2'b01; i_fifo_rx_data = 16'h005A;
        i_ch_sel = 1'b0; i_reg_sel = 1'b1; i_rd = 1'b1;
        #1;
        chk("t5_rd", o_reg_rd_data, 32'h0000_015A);
        chk("t5_pop", 32'(o_fifo_rx_pop_en), 32'h1);
        chk("t5_rxav", 32'(o_rxav), 32'h1);
        tick();
        i_fifo_rx_valid = 2'b00;
        #1;
        chk("t5_empty_rd", o_reg_rd_data, 32'h0);
        chk("t5_empty_pop", 32'(o_fifo_rx_pop_en), 32'h0);
        i_rd = 1'b0;
        tick();

        // 6: set/clear priority on ch1
        i_scdc_set_send = 2'b10; i_scdc_clear_send = 2'b10;
        ctrl_wr(1'b1, 32'h0000_00C1);
        i_scdc_set_send = '0; i_scdc_clear_send = '0;
        #1;
        chk("t6_send", 32'(o_send_req), 32'h0);
        i_scdc_set_read = 2'b10;
        tick();
        i_scdc_set_read = '0;
        #1;
        chk("t6_read", 32'(o_read_req), 32'h2);
        ctrl_rd_chk("t6_ctrl1", 1'b1, 32'h0000_00C2);

        // Agent write of send plus count fields on ch0
        ctrl_wr(1'b0, 32'h0000_0041);
        #1;
        chk("t7_send0", 32'(o_send_req), 32'h1);
        i_fifo_tx_count = {9'd0, 9'd5};
        i_fifo_rx_count = {9'd0, 9'd3};
        ctrl_rd_chk("t7_counts", 1'b0, 32'h0006_0541);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
